// File: rtl/eab_agu.sv
// Effective-address generator: base + sign-extended offset, then a strided
// burst of len+1 addresses with valid/ready handshaking and back-to-back requests.
module eab_agu #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned IR_W   = 11,
  parameter int unsigned OFF1_W = 6,
  parameter int unsigned OFF2_W = 9,
  parameter int unsigned OFF3_W = 11,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [IR_W-1:0]  IR,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] PC,
  input  logic             selBase,
  input  logic [1:0]       selOff,
  input  logic [LEN_W-1:0] len,
  input  logic             dirDown,
  output logic             addrValid,
  input  logic             addrReady,
  output logic [WIDTH-1:0] addrOut,
  output logic             addrLast,
  output logic             busy
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state;
  state_t           nextState;
  logic [LEN_W-1:0] beatCnt;
  logic [LEN_W-1:0] lenReg;
  logic             dirReg;
  logic [WIDTH-1:0] offset_c;
  logic [WIDTH-1:0] first_c;
  logic             accept_c;
  logic             xfer_c;

  // Offset field selection with sign extension to the address width
  always_comb begin
    offset_c = '0;
    case (selOff)
      2'd1:    offset_c = {{(WIDTH-OFF1_W){IR[OFF1_W-1]}}, IR[OFF1_W-1:0]};
      2'd2:    offset_c = {{(WIDTH-OFF2_W){IR[OFF2_W-1]}}, IR[OFF2_W-1:0]};
      2'd3:    offset_c = {{(WIDTH-OFF3_W){IR[OFF3_W-1]}}, IR[OFF3_W-1:0]};
      default: offset_c = '0;
    endcase
  end

  assign first_c  = (selBase ? Ra : PC) + offset_c;
  assign accept_c = reqValid && reqReady;
  assign xfer_c   = addrValid && addrReady;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // A new request accepted on the last beat keeps the FSM in BURST
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept_c) nextState = BURST;
      BURST:   if (xfer_c && addrLast && !accept_c) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    addrValid = 1'b0;
    reqReady  = 1'b0;
    busy      = (state == BURST);
    addrValid = busy;
    reqReady  = (state == IDLE) || (addrValid && addrLast && addrReady);
  end

  // Address/beat datapath; holds everything while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      addrOut  <= '0;
      addrLast <= 1'b0;
      beatCnt  <= '0;
      lenReg   <= '0;
      dirReg   <= 1'b0;
    end else if (accept_c) begin
      addrOut  <= first_c;
      addrLast <= (len == '0);
      beatCnt  <= '0;
      lenReg   <= len;
      dirReg   <= dirDown;
    end else if (xfer_c && !addrLast) begin
      addrOut  <= dirReg ? (addrOut - STEP) : (addrOut + STEP);
      beatCnt  <= beatCnt + LEN_W'(1);
      addrLast <= ((beatCnt + LEN_W'(1)) == lenReg);
    end
  end

endmodule

// File: doc/eab_agu.md
EAB_AGU -- requirements
Module: eab_agu

Interface
REQ-001 Parameters SHALL be as follows.
- WIDTH, default 16: address and operand width.
- IR_W, default 11: width of the instruction offset field.
- OFF1_W, default 6: offset width for selOff=1.
- OFF2_W, default 9: offset width for selOff=2.
- OFF3_W, default 11: offset width for selOff=3, with OFF1_W < OFF2_W < OFF3_W <= IR_W < WIDTH.
- LEN_W, default 4: burst length field width.
- STRIDE, default 1: unsigned per-beat address step, STRIDE < 2^WIDTH.
REQ-002 Ports SHALL be as follows.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request.
- IR  in  IR_W  instruction offset field.
- Ra  in  WIDTH  base register value.
- PC  in  WIDTH  program counter value.
- selBase  in  1  base select: 0=PC, 1=Ra.
- selOff  in  2  offset select: 0=zero, 1=sext(IR[OFF1_W-1:0]), 2=sext(IR[OFF2_W-1:0]), 3=sext(IR[OFF3_W-1:0]).
- len  in  LEN_W  beats minus one.
- dirDown  in  1  0 = addresses ascend, 1 = addresses descend.
- addrValid  out  1  addrOut is valid.
- addrReady  in  1  consumer accepts addrOut.
- addrOut  out  WIDTH  generated effective address.
- addrLast  out  1  marks the final beat of a burst.
- busy  out  1  burst in progress.

Function
REQ-003 A request SHALL be accepted on a rising edge where reqValid && reqReady; at acceptance, selBase, selOff, IR, Ra, PC, len and dirDown SHALL be captured, and later changes to them SHALL not affect the burst.
REQ-004 The first address SHALL be base + offset, with offset sign-extended to WIDTH and the sum taken modulo 2^WIDTH (carry discarded).
REQ-005 The burst SHALL produce exactly len+1 beats.
REQ-006 Beat k SHALL carry address first ± k*STRIDE modulo 2^WIDTH: + when dirDown=0, - when dirDown=1; wrap past 2^WIDTH-1 or below 0 SHALL be silent.
REQ-007 The state machine SHALL have two states, IDLE and BURST.
- IDLE -> BURST on acceptance.
- BURST -> IDLE when the last beat is accepted and no new request is accepted in the same cycle.
REQ-008 Latency SHALL be one cycle: addrValid=1 with the first address in the cycle after acceptance.
REQ-009 addrOut and addrLast SHALL be registered outputs, and they SHALL not change while addrValid && !addrReady (stall hold).
REQ-010 A beat SHALL transfer on a rising edge where addrValid && addrReady; the next beat SHALL appear in the following cycle with no bubble.
REQ-011 addrLast SHALL be 1 only on beat len; when len=0, the first beat SHALL be the last.
REQ-012 reqReady SHALL be 1 in IDLE, and SHALL be 1 in BURST only while addrValid && addrLast && addrReady (back-to-back).
- A request accepted in that cycle SHALL start its first beat in the next cycle with no idle cycle.
- reqReady may depend combinationally on addrReady; no other combinational input-to-output path is permitted.
REQ-013 busy SHALL be 1 exactly when the state is BURST.
REQ-014 addrValid SHALL equal busy.
REQ-015 Beat counting SHALL use an internal counter of LEN_W bits, so len = 2^LEN_W-1 yields 2^LEN_W beats with no counter overflow.
REQ-016 reqValid in BURST outside the back-to-back cycle SHALL be ignored and left pending; the requester holds it.
REQ-017 X/unknown values on data inputs while reqValid=0 SHALL not affect state.

Reset
REQ-018 When rst=1 at a rising edge, the following SHALL hold in the next cycle:
- state = IDLE.
- addrValid = 0, addrLast = 0, busy = 0, addrOut = 0.
- Beat counter = 0.
- reqReady = 1 in the next cycle.
REQ-019 Reset SHALL take priority over all handshakes.
- Reset mid-burst SHALL abandon the burst with no further beats.
- A request presented in the reset cycle SHALL not be accepted.

Verification
REQ-020 Legacy equivalence: WIDTH=16 defaults, len=0, selBase=0, PC=0x3000, selOff=2, IR[8:0]=0x1FF -> one beat, addrOut=0x2FFF, addrLast=1.
REQ-021 Ascending burst with stall: selBase=1, Ra=0x4000, selOff=1, IR[5:0]=0x05, len=3, dirDown=0, addrReady low in the 2nd valid cycle -> 0x4005, 0x4005 (held), 0x4006, 0x4007, 0x4008; addrLast only on 0x4008.
REQ-022 Wrap-around: Ra=0xFFFE, selOff=0, len=3, dirDown=0 -> 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-023 Descending wrap: Ra=0x0001, selOff=0, len=2, dirDown=1 -> 0x0001, 0x0000, 0xFFFF.
REQ-024 Back-to-back: second request (PC=0x1000, selOff=0, len=0) held valid during a len=1 burst -> reqReady=1 only in the last-beat cycle with addrReady=1; 0x1000 appears the very next cycle.
REQ-025 Reset mid-burst: rst=1 during beat 2 of len=7 -> next cycle addrValid=0, busy=0, addrOut=0, reqReady=1; a fresh request then starts from beat 0.
